// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@72Hz timing constants shared by the
// sync generator and decoder, plus the decoder FSM state type.
package vga_timing_pkg;

  localparam int ACTIVE_H    = 640;
  localparam int ACTIVE_V    = 480;
  localparam int HFP         = 24;
  localparam int HPULSE      = 40;
  localparam int HBP         = 128;
  localparam int VFP         = 9;
  localparam int VPULSE      = 3;
  localparam int VBP         = 28;
  localparam int LOCK_FRAMES = 2;

  localparam int BLACK_H = HFP + HPULSE + HBP;
  localparam int BLACK_V = VFP + VPULSE + VBP;
  localparam int H_TOTAL = ACTIVE_H + BLACK_H;
  localparam int V_TOTAL = ACTIVE_V + BLACK_V;
  localparam int WDOG    = 2 * H_TOTAL;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } sync_state_e;

  function automatic int wdog_limit(input int h_total);
    return 2 * h_total;
  endfunction

endpackage

// File: rtl/vga_sync_decoder_meter.sv
// vga_period_meter: falling-edge detect on an active-low sync,
// saturating event counter and capture of the count at each edge.
module vga_period_meter #(
  parameter int W         = 11,
  parameter bit CAP_PLUS1 = 1'b0,
  parameter bit KEEP_INC  = 1'b0
) (
  input  logic         px_clk,
  input  logic         reset_n,
  input  logic         sig,
  input  logic         inc,
  output logic         fall,
  output logic [W-1:0] cnt,
  output logic [W-1:0] meas
);

  logic         sig_q;
  logic [W-1:0] cnt_inc;

  assign fall    = sig_q & ~sig;
  assign cnt_inc = (inc && cnt != '1) ? cnt + 1'b1 : cnt;

  // an event coinciding with the edge belongs to the new period
  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      sig_q <= 1'b1;
      cnt   <= '0;
      meas  <= '0;
    end else begin
      sig_q <= sig;
      if (fall) begin
        meas <= CAP_PLUS1 ? cnt_inc : cnt;
        cnt  <= (KEEP_INC && inc) ? W'(1) : '0;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: locks onto hsync/vsync timing and regenerates
// pixel coordinates and activevideo one clock behind the counters.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE_H    = vga_timing_pkg::ACTIVE_H,
  parameter int ACTIVE_V    = vga_timing_pkg::ACTIVE_V,
  parameter int HFP         = vga_timing_pkg::HFP,
  parameter int HPULSE      = vga_timing_pkg::HPULSE,
  parameter int HBP         = vga_timing_pkg::HBP,
  parameter int VFP         = vga_timing_pkg::VFP,
  parameter int VPULSE      = vga_timing_pkg::VPULSE,
  parameter int VBP         = vga_timing_pkg::VBP,
  parameter int LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
  input  logic        px_clk,
  input  logic        reset_n,
  input  logic        hsync,
  input  logic        vsync,
  output logic [9:0]  x_px,
  output logic [9:0]  y_px,
  output logic        activevideo,
  output logic        locked,
  output logic [10:0] h_total_meas,
  output logic [10:0] v_total_meas
);

  localparam int BLACK_H = HFP + HPULSE + HBP;
  localparam int BLACK_V = VFP + VPULSE + VBP;
  localparam int H_TOTAL = ACTIVE_H + BLACK_H;
  localparam int V_TOTAL = ACTIVE_V + BLACK_V;
  localparam int WDOG    = wdog_limit(H_TOTAL);

  logic        hfall;
  logic        vfall;
  logic [10:0] hp;
  logic [10:0] lc;

  vga_period_meter #(
    .W(11),
    .CAP_PLUS1(1'b1),
    .KEEP_INC(1'b0)
  ) u_hmeter (
    .px_clk(px_clk),
    .reset_n(reset_n),
    .sig(hsync),
    .inc(1'b1),
    .fall(hfall),
    .cnt(hp),
    .meas(h_total_meas)
  );

  vga_period_meter #(
    .W(11),
    .CAP_PLUS1(1'b0),
    .KEEP_INC(1'b1)
  ) u_vmeter (
    .px_clk(px_clk),
    .reset_n(reset_n),
    .sig(vsync),
    .inc(hfall),
    .fall(vfall),
    .cnt(lc),
    .meas(v_total_meas)
  );

  logic [9:0]  hc;
  logic [9:0]  vc;
  logic        h_wrap;
  logic        h_bad;
  logic        v_bad;
  logic        wdog;
  sync_state_e state;
  logic [3:0]  good_cnt;
  logic        frame_ok;

  assign h_wrap = hc == 10'(H_TOTAL - 1);
  assign h_bad  = hfall && (hp + 11'd1 != 11'(H_TOTAL));
  assign v_bad  = vfall && (lc != 11'(V_TOTAL));
  assign wdog   = !hfall && (hp >= 11'(WDOG));

  // hsync is first seen low one clock into the pulse
  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc <= '0;
      vc <= '0;
    end else begin
      if (hfall)       hc <= 10'(HFP + 1);
      else if (h_wrap) hc <= '0;
      else             hc <= hc + 10'd1;
      if (vfall) begin
        vc <= 10'(VFP);
      end else if (h_wrap) begin
        vc <= (vc == 10'(V_TOTAL - 1)) ? '0 : vc + 10'd1;
      end
    end
  end

  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= SEARCH;
      good_cnt <= '0;
      frame_ok <= 1'b0;
      locked   <= 1'b0;
    end else if (wdog) begin
      state    <= SEARCH;
      good_cnt <= '0;
      frame_ok <= 1'b0;
      locked   <= 1'b0;
    end else begin
      unique case (state)
        SEARCH: begin
          good_cnt <= '0;
          frame_ok <= 1'b0;
          if (vfall) begin
            state    <= MEASURE;
            frame_ok <= !h_bad;
          end
        end
        MEASURE: begin
          if (vfall) begin
            frame_ok <= !h_bad;
            if (frame_ok && lc == 11'(V_TOTAL)) begin
              good_cnt <= good_cnt + 4'd1;
              if (good_cnt + 4'd1 >= 4'(LOCK_FRAMES)) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              good_cnt <= '0;
            end
          end else if (h_bad) begin
            frame_ok <= 1'b0;
          end
        end
        LOCKED: begin
          if (h_bad || v_bad) begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_px        <= '0;
      y_px        <= '0;
      activevideo <= 1'b0;
    end else begin
      x_px        <= hc - 10'(BLACK_H);
      y_px        <= vc - 10'(BLACK_V);
      activevideo <= locked && hc >= 10'(BLACK_H)
                            && vc >= 10'(BLACK_V);
    end
  end

endmodule
